// File: rtl/fanout_rx_pkg.sv
// Shared types and helpers for the fanned-out serial receiver and its matching transmitter bench.
package fanout_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        STOP
    } rx_state_t;

    localparam logic IDLE_LEVEL = 1'b1;

    // Majority of the low n bits of v; an even tie resolves to the idle level.
    function automatic logic maj_vote(logic [7:0] v, int n);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < n && v[i]) begin
                ones++;
            end
        end
        return (ones >= (n + 1) / 2) ? IDLE_LEVEL : ~IDLE_LEVEL;
    endfunction

endpackage

// File: rtl/fanout_rx_if.sv
// Received-word handshake: producer drives data/valid, consumer drives ready.
interface fanout_rx_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/fanout_vote.sv
// Combinational voter across the registered load copies of the serial line.
module fanout_vote
    import fanout_rx_pkg::*;
#(
    parameter int unsigned NUM_LOADS = 4
) (
    input  logic [NUM_LOADS-1:0] samp_i,
    output logic                 vote_o,
    output logic                 disagree_o
);

    logic [7:0] samp_ext;

    assign samp_ext   = 8'(samp_i);
    assign vote_o     = maj_vote(samp_ext, int'(NUM_LOADS));
    assign disagree_o = !(&samp_i) && (|samp_i);

endmodule

// File: rtl/fanout_rx.sv
// Receive end of a buffered broadcast net: votes the load copies, deframes start/data/stop
// words into a single-entry valid/ready slot and flags copy disagreement and framing faults.
module fanout_rx
    import fanout_rx_pkg::*;
#(
    parameter int unsigned NUM_LOADS = 4,
    parameter int unsigned DATA_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_LOADS-1:0] in_load,
    fanout_rx_if.master          rx_out,
    output logic                 mismatch_err,
    output logic                 frame_err,
    output logic                 overrun_err
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    rx_state_t            state_q;
    logic [NUM_LOADS-1:0] samp_q;
    logic [DATA_W-1:0]    shift_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [DATA_W-1:0]    out_data_q;
    logic                 out_valid_q;
    logic                 mismatch_q;
    logic                 frame_err_q;
    logic                 overrun_q;

    logic vote;
    logic disagree;

    fanout_vote #(
        .NUM_LOADS (NUM_LOADS)
    ) u_vote (
        .samp_i     (samp_q),
        .vote_o     (vote),
        .disagree_o (disagree)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            samp_q      <= {NUM_LOADS{IDLE_LEVEL}};
            shift_q     <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            mismatch_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            samp_q      <= in_load;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            if (disagree) begin
                mismatch_q <= 1'b1;
            end
            if (out_valid_q && rx_out.out_ready) begin
                out_valid_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (vote == ~IDLE_LEVEL) begin
                        shift_q <= '0;
                        cnt_q   <= '0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    shift_q <= {vote, shift_q[DATA_W-1:1]};
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    // A low stop bit is a framing fault, never the next start bit.
                    state_q <= IDLE;
                    if (vote == IDLE_LEVEL) begin
                        if (!out_valid_q || rx_out.out_ready) begin
                            out_data_q  <= shift_q;
                            out_valid_q <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_out.out_data  = out_data_q;
    assign rx_out.out_valid = out_valid_q;
    assign mismatch_err     = mismatch_q;
    assign frame_err        = frame_err_q;
    assign overrun_err      = overrun_q;

endmodule

// File: tb/tb_fanout_rx.sv
// Directed bench for fanout_rx with default parameters (4 loads, 8-bit words).
module tb_fanout_rx;

    localparam int unsigned NUM_LOADS = 4;
    localparam int unsigned DATA_W    = 8;

    logic                 clk;
    logic                 reset;
    logic [NUM_LOADS-1:0] in_load;
    logic                 mismatch_err;
    logic                 frame_err;
    logic                 overrun_err;

    int n_checks;
    int n_fail;

    fanout_rx_if #(.DATA_W(DATA_W)) rx_if ();

    fanout_rx #(
        .NUM_LOADS (NUM_LOADS),
        .DATA_W    (DATA_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_load      (in_load),
        .rx_out       (rx_if),
        .mismatch_err (mismatch_err),
        .frame_err    (frame_err),
        .overrun_err  (overrun_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic [NUM_LOADS-1:0] lv);
        in_load = lv;
        tick();
    endtask

    // Drives start, data LSB-first, then stop; inv_bit >= 0 inverts load 2 on that data bit.
    // On return the stop bit has been registered and the line is back at idle.
    task automatic send_frame(input logic [7:0] word, input logic stop_bit, input int inv_bit);
        logic [NUM_LOADS-1:0] lv;
        send_bit('0);
        for (int i = 0; i < int'(DATA_W); i++) begin
            lv = {NUM_LOADS{word[i]}};
            if (i == inv_bit) begin
                lv[2] = ~lv[2];
            end
            send_bit(lv);
        end
        send_bit({NUM_LOADS{stop_bit}});
        in_load = '1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        in_load = '1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        reset           = 1'b1;
        in_load         = '1;
        rx_if.out_ready = 1'b1;
        do_reset();

        check_val("rst_valid", 32'(rx_if.out_valid), 32'd0);
        check_val("rst_data", 32'(rx_if.out_data), 32'h00);
        check_val("rst_mismatch", 32'(mismatch_err), 32'd0);
        check_val("rst_frame", 32'(frame_err), 32'd0);
        check_val("rst_overrun", 32'(overrun_err), 32'd0);

        // Clean 0xA5
        send_frame(8'hA5, 1'b1, -1);
        check_val("a5_valid_early", 32'(rx_if.out_valid), 32'd0);
        tick();
        check_val("a5_valid", 32'(rx_if.out_valid), 32'd1);
        check_val("a5_data", 32'(rx_if.out_data), 32'hA5);
        tick();
        check_val("a5_valid_drop", 32'(rx_if.out_valid), 32'd0);
        check_val("a5_mismatch", 32'(mismatch_err), 32'd0);
        check_val("a5_frame", 32'(frame_err), 32'd0);
        check_val("a5_overrun", 32'(overrun_err), 32'd0);

        // 0xA5 with load 2 inverted on data bit 3
        do_reset();
        send_frame(8'hA5, 1'b1, 3);
        tick();
        check_val("inv_valid", 32'(rx_if.out_valid), 32'd1);
        check_val("inv_data", 32'(rx_if.out_data), 32'hA5);
        check_val("inv_mismatch", 32'(mismatch_err), 32'd1);
        for (int i = 0; i < 5; i++) tick();
        check_val("inv_mismatch_sticky", 32'(mismatch_err), 32'd1);
        do_reset();
        check_val("inv_mismatch_cleared", 32'(mismatch_err), 32'd0);

        // 2-2 tie held on the line: votes idle, no frame starts
        for (int i = 0; i < 12; i++) begin
            send_bit(4'b0011);
            check_val("tie_no_valid", 32'(rx_if.out_valid), 32'd0);
        end
        in_load = '1;
        tick();
        check_val("tie_mismatch", 32'(mismatch_err), 32'd1);
        send_frame(8'h11, 1'b1, -1);
        tick();
        check_val("tie_then_valid", 32'(rx_if.out_valid), 32'd1);
        check_val("tie_then_data", 32'(rx_if.out_data), 32'h11);
        tick();

        // Low stop bit after 0x3C, then clean 0x11
        do_reset();
        send_frame(8'h3C, 1'b0, -1);
        tick();
        check_val("fe_pulse", 32'(frame_err), 32'd1);
        check_val("fe_no_valid", 32'(rx_if.out_valid), 32'd0);
        check_val("fe_no_overrun", 32'(overrun_err), 32'd0);
        tick();
        check_val("fe_one_cycle", 32'(frame_err), 32'd0);
        check_val("fe_still_no_valid", 32'(rx_if.out_valid), 32'd0);
        send_frame(8'h11, 1'b1, -1);
        tick();
        check_val("fe_next_valid", 32'(rx_if.out_valid), 32'd1);
        check_val("fe_next_data", 32'(rx_if.out_data), 32'h11);
        tick();

        // Back-to-back 0x01, 0x02 with consumer stalled
        do_reset();
        rx_if.out_ready = 1'b0;
        send_frame(8'h01, 1'b1, -1);
        send_frame(8'h02, 1'b1, -1);
        check_val("ovr_first_held", 32'(rx_if.out_data), 32'h01);
        check_val("ovr_before", 32'(overrun_err), 32'd0);
        tick();
        check_val("ovr_pulse", 32'(overrun_err), 32'd1);
        check_val("ovr_data", 32'(rx_if.out_data), 32'h01);
        check_val("ovr_valid", 32'(rx_if.out_valid), 32'd1);
        check_val("ovr_no_frame", 32'(frame_err), 32'd0);
        tick();
        check_val("ovr_one_cycle", 32'(overrun_err), 32'd0);
        check_val("ovr_data_stable", 32'(rx_if.out_data), 32'h01);
        rx_if.out_ready = 1'b1;
        tick();
        check_val("ovr_consumed", 32'(rx_if.out_valid), 32'd0);
        check_val("ovr_no_repeat", 32'(overrun_err), 32'd0);

        // Reset mid-frame after four data bits of 0xFF
        do_reset();
        send_bit('0);
        for (int i = 0; i < 4; i++) send_bit('1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("mid_no_valid", 32'(rx_if.out_valid), 32'd0);
        check_val("mid_no_frame", 32'(frame_err), 32'd0);
        for (int i = 0; i < 8; i++) tick();
        check_val("mid_still_no_valid", 32'(rx_if.out_valid), 32'd0);
        check_val("mid_no_frame_later", 32'(frame_err), 32'd0);
        send_frame(8'h5A, 1'b1, -1);
        tick();
        check_val("mid_next_valid", 32'(rx_if.out_valid), 32'd1);
        check_val("mid_next_data", 32'(rx_if.out_data), 32'h5A);
        check_val("mid_mismatch", 32'(mismatch_err), 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fanout_rx.md
# fanout_rx

Serial receiver that terminates a broadcast net fanned out (and buffered) to several load pins. It samples every load copy, majority-votes the copies into one bit stream, deserializes start/data/stop frames into words, and presents them on a valid/ready output. It flags any disagreement between copies. It is the receive end of the broadcast driver used in resizer buffer-insertion test designs, and confirms that inserted buffers preserve the signal at every load.

## Interface
- `NUM_LOADS`, 4: number of load copies of the serial net; 1..8.
- `DATA_W`, 8: data bits per frame; 2..16.
- `clk` input 1: sole clock, all state on rising edge.
- `reset` input 1: synchronous, active-high.
- `in_load` input NUM_LOADS: one bit per buffered load copy of the serial line; idle level 1.
- `out_data` output DATA_W: received word.
- `out_valid` output 1: out_data holds an unconsumed word.
- `out_ready` input 1: consumer accepts the word when `out_valid && out_ready`.
- `mismatch_err` output 1: sticky; at least one sampled cycle had load copies that disagreed.
- `frame_err` output 1: one-cycle pulse; stop bit sampled as 0.
- `overrun_err` output 1: one-cycle pulse; a frame completed while the output slot was still full.

## Operation
- Sampling stage: `in_load` is registered once per cycle (`samp`).
- Vote: `bit = 1` if the number of ones in `samp` is at least ceil(NUM_LOADS/2). An even tie resolves to 1, the idle level.
- Disagree: `samp` is neither all-ones nor all-zeros. On any cycle this holds, `mismatch_err` is set and stays set until `reset`. The check runs in every state, including IDLE.
- FSM, one bit per cycle, no oversampling:
  - IDLE: if `bit==0` (start bit), clear `shift` and `cnt`, go to DATA. Otherwise stay.
  - DATA: shift `bit` in LSB-first (`shift <= {bit, shift[DATA_W-1:1]}`) and increment `cnt`. After DATA_W bits, go to STOP. `cnt` is ceil(log2(DATA_W+1)) bits wide.
  - STOP: if `bit==1`, deliver the word (below), then go to IDLE. If `bit==0`, pulse `frame_err`, discard the word, and go to IDLE. A 0 stop bit is never treated as the next start bit.
- Delivery into the single-entry output slot:
  - If the slot is empty, or is being consumed this same cycle (`out_valid && out_ready`), load `out_data <= shift` and keep `out_valid=1`.
  - Otherwise the slot is full and not consumed: pulse `overrun_err`, drop the new word, and keep the old one.
- Handshake: `out_data` is stable while `out_valid && !out_ready`. `out_valid` falls on the cycle after acceptance unless a new word is loaded in that same cycle.

## Timing
- Reset values: FSM=IDLE, `samp`=all ones, `shift`=0, `cnt`=0, `out_data`=0, `out_valid`=0, `mismatch_err`=0, `frame_err`=0, `overrun_err`=0.
- Latency: the stop bit is on `in_load` in cycle T. It is registered at edge T+1, evaluated in STOP, and `out_valid` rises after edge T+2.
- A start bit is recognized at least one cycle after a stop bit. Back-to-back frames with no idle gap are therefore supported at DATA_W+2 cycles per frame.
- `reset` asserted mid-frame returns to IDLE on the next edge. A partial word is never delivered, and all error flags clear.
- `frame_err` and `overrun_err` each last exactly one cycle per event. Both can never fire for the same frame.

## Structure
- Shared package `fanout_rx_pkg`:
  - state enum `rx_state_t` {IDLE, DATA, STOP};
  - `IDLE_LEVEL = 1'b1`;
  - function `maj_vote(logic [7:0] v, int n)`, reused by the matching transmitter bench.
- Sub-module `fanout_vote`, purely combinational: it takes `samp` and produces `bit` and `disagree`. The FSM and output slot stay in `fanout_rx`.

## Test plan
All scenarios use defaults unless stated; each bit is driven for one cycle.
- Clean frame, all loads equal, 0xA5 = start 0, bits 1,0,1,0,0,1,0,1, stop 1, with `out_ready=1` → `out_data=0xA5` and `out_valid` high for exactly one cycle, 2 cycles after the stop bit; all errors stay 0.
- Same frame, but load 2 is inverted on data bit 3 only → `out_data=0xA5` (the majority wins); `mismatch_err` rises and stays 1 until `reset`.
- NUM_LOADS=4, tie 2-2 on every bit of the line → vote is 1 and the FSM stays in IDLE; `mismatch_err`=1; no word is delivered.
- Stop bit driven 0 after 0x3C → one-cycle `frame_err`; `out_valid` stays 0; a following clean 0x11 frame is received correctly.
- `out_ready=0`, frames 0x01 then 0x02 back-to-back → `out_data` holds 0x01 and `overrun_err` pulses once. Raising `out_ready` consumes 0x01, and `out_valid` then drops.
- `reset` pulsed after 4 data bits of 0xFF → no delivery, state returns to IDLE, and a subsequent 0x5A frame is received intact.
